// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller: per-stage write enables and clears plus PC redirect sequencing.
// Optional MEM2 TLB-instruction refetch redirect is enabled by defining PIPE_CTRL_TLB_REFETCH_EN.
//
// state | meaning
// RUN   | normal issue; stalls resolved by priority, flush events captured here
// DRAIN | redirect pending, waiting for the outstanding fetch to return and be dropped
// REDIR | single cycle in which PF loads redirect_pc
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_RS,
  input  logic [4:0]  ID_RT,
  input  logic        EX_DMRd,
  input  logic [4:0]  EX_RD,
  input  logic        icache_stall,
  input  logic        dcache_stall,
  input  logic        div_busy,
  input  logic        MEM1_flush_req,
  input  logic [31:0] MEM1_target,
  input  logic        MEM2_TLB_refetch,
  input  logic [31:0] MEM2_PC,
  output logic        PF_IFWr,
  output logic        IF_IDWr,
  output logic        ID_EXWr,
  output logic        EX_MEM1Wr,
  output logic        MEM1_MEM2Wr,
  output logic        MEM2_WBWr,
  output logic        IF_Flush,
  output logic        ID_Flush,
  output logic        EX_Flush,
  output logic        MEM1_Flush,
  output logic        MEM2_Flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fetch_discard
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] redirect_pc_nx;
  logic        load_use;
  logic        tlb_evt;
  logic        flush_evt;
  logic [31:0] flush_target;

  assign load_use = EX_DMRd && (EX_RD != 5'd0) && ((EX_RD == ID_RS) || (EX_RD == ID_RT));

`ifdef PIPE_CTRL_TLB_REFETCH_EN
  // Refetch restarts after the TLB instruction; it wins over MEM1 because MEM1 is younger.
  assign tlb_evt      = MEM2_TLB_refetch;
  assign flush_target = tlb_evt ? (MEM2_PC + 32'd4) : MEM1_target;
`else
  logic unused_tlb;
  assign unused_tlb   = ^{MEM2_TLB_refetch, MEM2_PC};
  assign tlb_evt      = 1'b0;
  assign flush_target = MEM1_target;
`endif

  // A flush held off by a dcache stall is simply re-presented once the stall clears.
  assign flush_evt  = !dcache_stall && (MEM1_flush_req || tlb_evt);
  assign MEM2_Flush = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      redirect_pc <= 32'd0;
    end else begin
      state       <= state_nx;
      redirect_pc <= redirect_pc_nx;
    end
  end

  always_comb begin
    PF_IFWr        = 1'b1;
    IF_IDWr        = 1'b1;
    ID_EXWr        = 1'b1;
    EX_MEM1Wr      = 1'b1;
    MEM1_MEM2Wr    = 1'b1;
    MEM2_WBWr      = 1'b1;
    IF_Flush       = 1'b0;
    ID_Flush       = 1'b0;
    EX_Flush       = 1'b0;
    MEM1_Flush     = 1'b0;
    redirect_valid = 1'b0;
    fetch_discard  = 1'b0;
    state_nx       = state;
    redirect_pc_nx = redirect_pc;

    case (state)
      RUN: begin
        if (flush_evt) begin
          PF_IFWr        = 1'b0;
          IF_Flush       = 1'b1;
          ID_Flush       = 1'b1;
          EX_Flush       = 1'b1;
          MEM1_Flush     = 1'b1;
          redirect_pc_nx = flush_target;
          state_nx       = icache_stall ? DRAIN : REDIR;
        end else if (dcache_stall) begin
          PF_IFWr     = 1'b0;
          IF_IDWr     = 1'b0;
          ID_EXWr     = 1'b0;
          EX_MEM1Wr   = 1'b0;
          MEM1_MEM2Wr = 1'b0;
          MEM2_WBWr   = 1'b0;
        end else if (div_busy) begin
          PF_IFWr   = 1'b0;
          IF_IDWr   = 1'b0;
          ID_EXWr   = 1'b0;
          EX_MEM1Wr = 1'b0;
          EX_Flush  = 1'b1;
        end else if (load_use) begin
          PF_IFWr  = 1'b0;
          IF_IDWr  = 1'b0;
          ID_Flush = 1'b1;
        end else if (icache_stall) begin
          PF_IFWr  = 1'b0;
          IF_Flush = 1'b1;
        end
      end

      DRAIN: begin
        fetch_discard = 1'b1;
        IF_Flush      = 1'b1;
        PF_IFWr       = 1'b0;
        IF_IDWr       = 1'b0;
        ID_EXWr       = 1'b0;
        EX_MEM1Wr     = 1'b0;
        MEM1_MEM2Wr   = !dcache_stall;
        MEM2_WBWr     = !dcache_stall;
        if (!icache_stall) state_nx = REDIR;
      end

      REDIR: begin
        redirect_valid = 1'b1;
        IF_Flush       = 1'b1;
        state_nx       = RUN;
      end

      default: state_nx = RUN;
    endcase
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high, ports clk and rst.
REQ-002 clk  in  1  pipeline clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ID_RS  in  5  rs field of instruction in ID.
REQ-005 ID_RT  in  5  rt field of instruction in ID.
REQ-006 EX_DMRd  in  1  EX instruction is a load.
REQ-007 EX_RD  in  5  EX destination register.
REQ-008 icache_stall  in  1  IF fetch not complete this cycle.
REQ-009 dcache_stall  in  1  MEM2 access not complete this cycle.
REQ-010 div_busy  in  1  EX multicycle divide still running.
REQ-011 MEM1_flush_req  in  1  exception or eret committing in MEM1.
REQ-012 MEM1_target  in  32  CP0 redirect PC (vector or EPC).
REQ-013 MEM2_TLB_refetch  in  1  tlbwr/tlbr/tlbp in MEM2 (macro only).
REQ-014 MEM2_PC  in  32  PC of MEM2 instruction.
REQ-015 PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr  out  1 each  pipeline-register write enables.
REQ-016 IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush  out  1 each  pipeline-register clears (flush dominates Wr).
REQ-017 redirect_valid  out  1  PF loads redirect_pc this cycle.
REQ-018 redirect_pc  out  32  registered redirect target.
REQ-019 fetch_discard  out  1  in-flight instruction fetch returns data to be dropped.

Function
REQ-020 SHALL implement FSM {RUN, DRAIN, REDIR}; Wr/Flush are combinational from state and inputs; redirect_pc, state registered.
REQ-021 RUN default: all Wr=1, all Flush=0, redirect_valid=0, fetch_discard=0; MEM2_Flush is always 0.
REQ-022 RUN stall priority, highest first: flush event > dcache_stall > div_busy > load_use > icache_stall.
REQ-023 load_use = EX_DMRd & (EX_RD!=0) & (EX_RD==ID_RS | EX_RD==ID_RT).
REQ-024 dcache_stall: all six Wr=0, no Flush.
REQ-025 div_busy: PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr=0; EX_Flush=1 (bubble into MEM1); MEM1_MEM2Wr, MEM2_WBWr=1.
REQ-026 load_use: PF_IFWr, IF_IDWr=0; ID_Flush=1 (bubble into EX); later stages advance.
REQ-027 icache_stall alone: PF_IFWr=0, IF_Flush=1 (bubble into ID); later stages advance; IF_Flush=0 whenever IF_IDWr=0 for higher priority.
REQ-028 Flush event (RUN, dcache_stall=0, MEM1_flush_req=1): IF_Flush, ID_Flush, EX_Flush, MEM1_Flush=1; PF_IFWr=0; redirect_pc<=MEM1_target; next state DRAIN if icache_stall else REDIR.
REQ-029 MEM1_flush_req with dcache_stall=1 SHALL be held off (pure stall) until dcache_stall=0.
REQ-030 DRAIN: fetch_discard=1, IF_Flush=1, PF_IFWr=0, IF_IDWr..EX_MEM1Wr=0; MEM1_MEM2Wr, MEM2_WBWr=~dcache_stall; exit to REDIR on icache_stall=0.
REQ-031 REDIR: exactly one cycle; redirect_valid=1, PF_IFWr=1, IF_Flush=1; next RUN.
REQ-032 MEM1_flush_req and load_use/div_busy SHALL be ignored in DRAIN and REDIR.

Reset
REQ-033 rst=1 at clock edge: state<=RUN, redirect_pc<=0; rst mid-DRAIN/REDIR aborts redirect; outputs decode as RUN next cycle.

Configuration
REQ-034 Macro PIPE_CTRL_TLB_REFETCH_EN defined: MEM2_TLB_refetch=1 with dcache_stall=0 in RUN is a flush event per REQ-028 with redirect_pc<=MEM2_PC+4 (mod 2^32), beating a simultaneous MEM1_flush_req (MEM1 instruction flushed).
REQ-035 Macro undefined: MEM2_TLB_refetch ignored; no adder present.

Verification
REQ-036 EX_DMRd=1, EX_RD=5, ID_RS=5 -> IF_IDWr=0, PF_IFWr=0, ID_Flush=1; EX_RD=0 -> no stall.
REQ-037 div_busy=1 for 10 cycles -> EX_Flush=1 and EX_MEM1Wr=0 for 10 cycles, MEM2_WBWr=1.
REQ-038 MEM1_flush_req=1, MEM1_target=0xBFC00380, icache_stall=0 -> four flushes same cycle; next cycle redirect_valid=1, redirect_pc=0xBFC00380; then RUN.
REQ-039 Same with icache_stall=1 for 3 more cycles -> fetch_discard=1 for 3 cycles, redirect_valid one cycle later.
REQ-040 MEM1_flush_req with dcache_stall=1 for 4 cycles -> all Wr=0, no flush until cycle 5.
REQ-041 Macro on: MEM2_TLB_refetch=1, MEM2_PC=0xFFFFFFFC, MEM1_flush_req=1 -> redirect_pc=0x00000000.
